// File: rtl/pulse_dec_pkg.sv
// ============================================================================
// pulse_dec_pkg : shared types and constants for the pulse train decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package pulse_dec_pkg;

  localparam int SAMPLE_W   = 14;
  localparam int CODE_W     = 2;
  localparam int MAX_PULSES = 3;
  // One extra pulse beyond MAX_PULSES is tracked so an overflow can be flagged.
  localparam int CNT_W      = $clog2(MAX_PULSES + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pulse_dec_slicer.sv
// ============================================================================
// pulse_dec_slicer : input sample register and threshold level slicer
// Option: PULSE_DEC_HYST_EN enables THRESH_LO hysteresis. Rev 1.0
// ============================================================================
`default_nettype none

module pulse_dec_slicer
  import pulse_dec_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] THRESH_HI = 14'sd4000,
  parameter logic signed [SAMPLE_W-1:0] THRESH_LO = 14'sd2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sigin_i,
  output logic                       level_o
);

  logic signed [SAMPLE_W-1:0] sample_q;

  always_ff @(posedge clk) begin
    if (rst) sample_q <= '0;
    else     sample_q <= sigin_i;
  end

`ifdef PULSE_DEC_HYST_EN
  logic level_q;
  logic level_d;

  // Level follows the registered sample directly; level_q only remembers the
  // previous decision while the sample sits inside the hysteresis band.
  always_comb begin
    level_d = level_q;
    if (sample_q > THRESH_HI)      level_d = 1'b1;
    else if (sample_q < THRESH_LO) level_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_d;
  end

  assign level_o = level_d;
`else
  assign level_o = (sample_q > THRESH_HI);
`endif

endmodule

`default_nettype wire

// File: rtl/pulse_train_decoder.sv
// ============================================================================
// pulse_train_decoder : counts qualified pulses in a train and emits the count
// Option: PULSE_DEC_HYST_EN (slicer hysteresis). Rev 1.0
// ============================================================================
`default_nettype none

module pulse_train_decoder
  import pulse_dec_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] THRESH_HI  = 14'sd4000,
  parameter logic signed [SAMPLE_W-1:0] THRESH_LO  = 14'sd2000,
  parameter int                         MIN_WIDTH  = 4,
  parameter int                         GAP_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic signed [SAMPLE_W-1:0] sigin,
  output logic [CODE_W-1:0]          code,
  output logic                       code_valid,
  output logic                       overflow
);

  localparam int                 c_wid_w    = $clog2(MIN_WIDTH + 1);
  localparam int                 c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_wid_w-1:0] c_wid_max  = c_wid_w'(MIN_WIDTH);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_cnt_sat  = CNT_W'(MAX_PULSES + 1);

  logic level;

  pulse_dec_slicer #(
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_slicer (
    .clk     (clk),
    .rst     (rst),
    .sigin_i (sigin),
    .level_o (level)
  );

  state_e              state_q, state_d;
  logic [c_wid_w-1:0]  wid_q, wid_d;
  logic [c_gap_w-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wid_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wid_q   <= wid_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wid_d   = wid_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    if (!ena) begin
      state_d = ST_IDLE;
      wid_d   = '0;
      gap_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level) begin
            state_d = ST_HIGH;
            wid_d   = c_wid_w'(1);
            gap_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_HIGH: begin
          if (level) begin
            if (wid_q < c_wid_max) wid_d = wid_q + c_wid_w'(1);
          end else begin
            wid_d = '0;
            gap_d = '0;
            // A short pulse is a glitch: it neither counts nor ends the train.
            if (wid_q >= c_wid_max) begin
              if (cnt_q < c_cnt_sat) cnt_d = cnt_q + CNT_W'(1);
              state_d = ST_GAP;
            end else begin
              state_d = (cnt_q != '0) ? ST_GAP : ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == c_gap_last) begin
            state_d = ST_EMIT;
          end else if (level) begin
            state_d = ST_HIGH;
            wid_d   = c_wid_w'(1);
          end else begin
            gap_d = gap_q + c_gap_w'(1);
          end
        end
        ST_EMIT: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gap_d   = '0;
          wid_d   = '0;
          if (cnt_q == c_cnt_sat) begin
            ovf_d = 1'b1;
          end else if (cnt_q != '0) begin
            valid_d = 1'b1;
            code_d  = cnt_q[CODE_W-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_decoder.sv
// ============================================================================
// tb_pulse_train_decoder : directed and randomized checks of pulse_train_decoder
// Option: PULSE_DEC_HYST_EN selects hysteresis expectations. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_train_decoder;
  import pulse_dec_pkg::*;

  localparam int GAP  = 32;
  localparam int MINW = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       ena;
  logic signed [SAMPLE_W-1:0] sigin;
  logic [CODE_W-1:0]          code;
  logic                       code_valid;
  logic                       overflow;

  int cyc     = 0;
  int nassert = 0;
  int nfail   = 0;
  int tv      = 0;
  int to      = 0;
  int vcyc    = -1;
  int vcode   = -1;
  int ocyc    = -1;
  int b_v;
  int b_o;

  pulse_train_decoder #(
    .THRESH_HI  (14'sd4000),
    .THRESH_LO  (14'sd2000),
    .MIN_WIDTH  (MINW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .sigin      (sigin),
    .code       (code),
    .code_valid (code_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Strobe monitor: cumulative counts plus cycle stamp of the latest strobe.
  always @(negedge clk) begin
    if (code_valid) begin
      tv    <= tv + 1;
      vcyc  <= cyc;
      vcode <= int'(code);
    end
    if (overflow) begin
      to   <= to + 1;
      ocyc <= cyc;
    end
  end

  task automatic step(input logic signed [SAMPLE_W-1:0] s);
    sigin = s;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse(input int w, input int amp);
    repeat (w) step(SAMPLE_W'(amp));
  endtask

  task automatic lows(input int n);
    repeat (n) step('0);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nassert++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_train();
    b_v = tv;
    b_o = to;
  endtask

  // f = cycle of the first low sample after the last qualified pulse.
  task automatic expect_train(input string tag, input int cnt, input int f, input int hold);
    lows(GAP + 8);
    if (cnt >= 1 && cnt <= MAX_PULSES) begin
      chk({tag, "_nvalid"}, tv - b_v, 1);
      chk({tag, "_code"}, vcode, cnt);
      chk({tag, "_vcyc"}, vcyc, f + GAP + 2);
      chk({tag, "_novf"}, to - b_o, 0);
      chk({tag, "_hold"}, int'(code), cnt);
    end else if (cnt > MAX_PULSES) begin
      chk({tag, "_nvalid"}, tv - b_v, 0);
      chk({tag, "_novf"}, to - b_o, 1);
      chk({tag, "_ocyc"}, ocyc, f + GAP + 2);
      chk({tag, "_hold"}, int'(code), hold);
    end else begin
      chk({tag, "_nvalid"}, tv - b_v, 0);
      chk({tag, "_novf"}, to - b_o, 0);
      chk({tag, "_hold"}, int'(code), hold);
    end
  endtask

  initial begin
    int f;
    int hold;
    int n;
    int vcount;
    int w;
    int exp_cnt;

    rst   = 1'b1;
    ena   = 1'b1;
    sigin = '0;
    step(14'sd8000);
    step(14'sd8000);
    step('0);
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    lows(2);

    // Two 10-cycle pulses, 5 apart.
    begin_train();
    pulse(10, 8000); lows(5); pulse(10, 8000);
    f = cyc + 1;
    expect_train("two_pulse", 2, f, 0);

    // A 3-cycle glitch between two valid pulses is ignored.
    begin_train();
    pulse(10, 8000); lows(5); pulse(3, 8000); lows(5); pulse(10, 8000);
    f = cyc + 1;
    expect_train("glitch", 2, f, 0);

    // Five pulses overflow; code keeps its previous value.
    begin_train();
    hold = int'(code);
    for (int i = 0; i < 5; i++) begin
      pulse(6, 8000);
      if (i < 4) lows(4);
    end
    f = cyc + 1;
    expect_train("overflow", 4, f, hold);

    // ena dropped mid-train abandons it.
    begin_train();
    hold = int'(code);
    pulse(10, 8000); lows(5); pulse(10, 8000); lows(3);
    ena = 1'b0;
    lows(4);
    ena = 1'b1;
    expect_train("ena_abort", 0, 0, hold);
    begin_train();
    pulse(10, 8000);
    f = cyc + 1;
    expect_train("after_ena", 1, f, 0);

    // rst mid-train abandons it and clears code.
    begin_train();
    pulse(10, 8000); lows(5); pulse(10, 8000); lows(3);
    rst = 1'b1;
    step('0);
    rst = 1'b0;
    chk("rst_mid_code", int'(code), 0);
    expect_train("rst_abort", 0, 0, 0);
    begin_train();
    pulse(10, 8000);
    f = cyc + 1;
    expect_train("after_rst", 1, f, 0);

    // Negative samples never register as high.
    begin_train();
    hold = int'(code);
    for (int i = 0; i < 3; i++) begin
      pulse(10, -8000);
      lows(5);
    end
    expect_train("negative", 0, 0, hold);

    // 8000 -> 3000 -> 1000: the fall point moves with hysteresis.
    begin_train();
    pulse(5, 8000);
`ifdef PULSE_DEC_HYST_EN
    f = cyc + 2;
`else
    f = cyc + 1;
`endif
    step(14'sd3000);
    step(14'sd1000);
    expect_train("hyst_fall", 1, f, 0);

    // 3 high + 2 in-band samples: a valid pulse only when hysteresis holds it.
    begin_train();
    hold = int'(code);
    pulse(3, 8000);
    pulse(2, 3000);
    f = cyc + 1;
`ifdef PULSE_DEC_HYST_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    expect_train("hyst_band", exp_cnt, f, hold);

    // Randomized trains against a width-count model.
    for (int t = 0; t < 10; t++) begin
      begin_train();
      hold   = int'(code);
      n      = int'($urandom_range(1, 5));
      vcount = 0;
      for (int i = 0; i < n; i++) begin
        w = (i == n - 1) ? int'($urandom_range(MINW, 12)) : int'($urandom_range(1, 12));
        if (w >= MINW) vcount++;
        pulse(w, int'($urandom_range(4001, 8191)));
        if (i < n - 1) begin
          repeat (int'($urandom_range(1, 20))) step(SAMPLE_W'(int'($urandom_range(0, 10191)) - 8192));
        end
      end
      f = cyc + 1;
      exp_cnt = (vcount > MAX_PULSES + 1) ? MAX_PULSES + 1 : vcount;
      expect_train($sformatf("rand%0d", t), exp_cnt, f, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

`default_nettype wire
